// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file access arbiter.
//   RF_AW / RF_DW : register file address / data width (64 x 32)
//   rf_op_e       : requester operation (OP_READ = 0, OP_WRITE = 1)
//   rf_req_t      : one requester's transaction fields {we, addr, wdata}
// -----------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int RF_AW = 6;
    localparam int RF_DW = 32;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } rf_op_e;

    typedef struct packed {
        rf_op_e              we;
        logic [RF_AW-1:0]    addr;
        logic [RF_DW-1:0]    wdata;
    } rf_req_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at ptr and
// wraps modulo N; the first asserted request wins.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index of the highest-priority requester this cycle
//   gnt  out N   one-hot grant (all zero when nothing requests)
//   win  out IW  index of the winner (0 when nothing requests)
//   any  out 1   at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    int idx;

    always_comb begin
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                win      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// -----------------------------------------------------------------------------
// rf_access_arbiter
// Shares the register file's write port and src1 read port between NREQ
// requesters, granting at most one transaction per cycle in round-robin order.
// Ports:
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   req, req_we       per-requester request and op (1 = write, 0 = read)
//   req_addr          packed addresses, requester k at [k*AW +: AW]
//   req_wdata         packed write data, requester k at [k*DW +: DW]
//   req_lock          (only with RF_ARB_LOCK_EN) keep ownership while high
//   gnt               one-hot combinational accept strobe
//   rvalid, rdata     registered read-valid (one-hot) and read data
//   rf_reg_write, rf_src1_addr, rf_write_addr, rf_write_data  to register file
//   rf_src1           src1 data from the register file (registered there)
// Optional feature macro: RF_ARB_LOCK_EN (adds req_lock for atomic bursts).
// -----------------------------------------------------------------------------
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 rf_reg_write,
    output logic [AW-1:0]        rf_src1_addr,
    output logic [AW-1:0]        rf_write_addr,
    output logic [DW-1:0]        rf_write_data,
    input  logic [DW-1:0]        rf_src1
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rf_req_t         fld [NREQ];
    rf_req_t         sel;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   win;
    logic            any;
    logic            grant_wr, grant_rd;
    logic            rd_pend_reg;
    logic [IW-1:0]   rd_owner_reg;
    logic [AW-1:0]   src1_addr_reg;

    // Unpack the flat request buses into per-requester records.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign fld[gi] = '{we:    rf_op_e'(req_we[gi]),
                               addr:  req_addr[gi*AW +: AW],
                               wdata: req_wdata[gi*DW +: DW]};
        end
    endgenerate

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .gnt (gnt),
        .win (win),
        .any (any)
    );

    assign sel      = fld[win];
    assign grant_wr = any && (sel.we == OP_WRITE);
    assign grant_rd = any && (sel.we == OP_READ);

    always_comb begin
        ptr_next = ptr_reg;
        if (any) begin
            if (win == IW'(NREQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = win + IW'(1);
            end
`ifdef RF_ARB_LOCK_EN
            // A locked owner keeps top priority so its burst stays atomic.
            if (req_lock[win]) begin
                ptr_next = win;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            rd_pend_reg   <= 1'b0;
            rd_owner_reg  <= '0;
            src1_addr_reg <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            rd_pend_reg <= grant_rd;
            if (grant_rd) begin
                rd_owner_reg  <= win;
                src1_addr_reg <= sel.addr;
            end
        end
    end

    // The register file's src1 register lines up with rd_pend one cycle later.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rvalid
            assign rvalid[gi] = rd_pend_reg && (rd_owner_reg == IW'(gi));
        end
    endgenerate

    assign rdata         = rf_src1;
    // Reset gating keeps a half-cycle grant from corrupting the register file.
    assign rf_reg_write  = grant_wr && !rst;
    assign rf_write_addr = sel.addr;
    assign rf_write_data = sel.wdata;
    // Holding the last read address keeps rf_src1 stable on idle/write cycles.
    assign rf_src1_addr  = grant_rd ? sel.addr : src1_addr_reg;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_access_arbiter
// Directed + random bench for rf_access_arbiter with a behavioural register
// file and a transaction-level reference model (grant order, memory image,
// expected read data). Define RF_ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_rf_access_arbiter;

    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
`ifdef RF_ARB_LOCK_EN
    logic [N-1:0]      req_lock;
`endif
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, rf_write_data, rf_src1;
    logic              rf_reg_write;
    logic [AW-1:0]     rf_src1_addr, rf_write_addr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] mem_exp [64];
    int            nxt;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] last_rd;
    bit            have_rd;

    // Behavioural register file: src1 registered, updated only when not writing.
    logic [DW-1:0] rf_mem [64];
    always @(posedge clk) begin
        if (rf_reg_write) rf_mem[rf_write_addr] <= rf_write_data;
        else              rf_src1 <= rf_mem[rf_src1_addr];
    end

    always #5 clk = ~clk;

    rf_access_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
`ifdef RF_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rf_reg_write  (rf_reg_write),
        .rf_src1_addr  (rf_src1_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_src1       (rf_src1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        nxt     = 0;
        exp_rv  = '0;
        have_rd = 1'b0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, update model.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] we,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                        input logic [N-1:0] lk, output int win);
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [N-1:0]  eg;
        req = r; req_we = we; req_addr = a; req_wdata = d;
`ifdef RF_ARB_LOCK_EN
        req_lock = lk;
`endif
        #1;
        win = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (nxt + i) % N;
            if (win < 0 && r[k]) win = k;
        end
        eg = (win < 0) ? '0 : N'(1 << win);
        wa = '0; wd = '0;
        if (win >= 0) begin
            wa = a[win*AW +: AW];
            wd = d[win*DW +: DW];
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rdata", rdata, exp_rd);
        if (win >= 0 && we[win]) begin
            chk("reg_write", 32'(rf_reg_write), 32'd1);
            chk("write_addr", 32'(rf_write_addr), 32'(wa));
            chk("write_data", rf_write_data, wd);
        end else begin
            chk("reg_write", 32'(rf_reg_write), 32'd0);
            if (win >= 0) chk("src1_addr", 32'(rf_src1_addr), 32'(wa));
            else if (have_rd) chk("src1_hold", 32'(rf_src1_addr), 32'(last_rd));
        end
        @(posedge clk);
        exp_rv = '0;
        if (win >= 0) begin
            if (we[win]) begin
                mem_exp[wa] = wd;
            end else begin
                exp_rv  = N'(1 << win);
                exp_rd  = mem_exp[wa];
                last_rd = wa;
                have_rd = 1'b1;
            end
            nxt = lk[win] ? win : (win + 1) % N;
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w, prev;
        logic [DW-1:0] pre0, pv;
        logic [N-1:0] p_act, p_we;
        logic [AW-1:0] p_addr [N];
        logic [DW-1:0] p_data [N];
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;

        // ---------------- reset ----------------
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef RF_ARB_LOCK_EN
        req_lock = '0;
`endif
        model_reset();
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        req = 2'b01; req_we = 2'b01; req_addr = {6'd0, 6'd9};
        #1;
        chk("rst_no_write", 32'(rf_reg_write), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; req = '0;

        // ---------------- single write then read ----------------
        step(2'b01, 2'b01, {6'd0, 6'd5}, {32'h0, 32'hDEADBEEF}, 2'b00, w);
        chk("t1_win", 32'(w), 32'd0);
        step(2'b01, 2'b00, {6'd0, 6'd5}, '0, 2'b00, w);
        chk("t1_rvalid", 32'(rvalid), 32'd1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);

        // ---------------- preload ----------------
        for (int i = 0; i < 64; i++) begin
            if (i == 5) continue;
            pv = (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : $urandom;
            if (i == 0) pre0 = pv;
            step(2'b01, 2'b01, {6'd0, 6'(i)}, {32'h0, pv}, 2'b00, w);
        end

        // ---------------- contention, both reading ----------------
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, {6'd2, 6'd1}, '0, 2'b00, w);
            if (prev >= 0) chk("alt_grant", 32'(w != prev), 32'd1);
            chk("alt_rvalid", 32'(rvalid), 32'(1 << w));
            chk("alt_rdata", rdata, (w == 0) ? 32'h11 : 32'h22);
            prev = w;
        end

        // ---------------- read-after-write ----------------
        step(2'b10, 2'b10, {6'd63, 6'd0}, {32'hA5A5A5A5, 32'h0}, 2'b00, w);
        chk("raw_wr_win", 32'(w), 32'd1);
        step(2'b01, 2'b00, {6'd0, 6'd63}, '0, 2'b00, w);
        chk("raw_rvalid", 32'(rvalid), 32'd1);
        chk("raw_rdata", rdata, 32'hA5A5A5A5);
        step(2'b01, 2'b00, {6'd0, 6'd0}, '0, 2'b00, w);
        chk("raw_addr0", rdata, pre0);

        // ---------------- idle stability ----------------
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 2'b00, '0, '0, 2'b00, w);
            chk("idle_gnt", 32'(w + 1), 32'd0);
        end
        step(2'b01, 2'b00, {6'd0, 6'd5}, '0, 2'b00, w);
        chk("idle_readback", rdata, 32'hDEADBEEF);
        step(2'b00, 2'b00, '0, '0, 2'b00, w);

        // ---------------- async reset mid-read ----------------
        // Make requester 1 next in line, then reset before the rvalid cycle ends.
        step(2'b01, 2'b01, {6'd0, 6'd7}, {32'h0, 32'h0707}, 2'b00, w);
        req = 2'b01; req_we = 2'b00; req_addr = {6'd0, 6'd1};
        #1;
        chk("mr_gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        chk("mr_reg_write", 32'(rf_reg_write), 32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(2'b11, 2'b00, {6'd2, 6'd1}, '0, 2'b00, w);
        chk("mr_first", 32'(w), 32'd0);

`ifdef RF_ARB_LOCK_EN
        // ---------------- locked burst ----------------
        step(2'b11, 2'b11, {6'd10, 6'd20}, {32'h1010, 32'h2020}, 2'b10, w);
        chk("lock_1", 32'(w), 32'd1);
        step(2'b11, 2'b11, {6'd11, 6'd20}, {32'h1111, 32'h2020}, 2'b10, w);
        chk("lock_2", 32'(w), 32'd1);
        step(2'b11, 2'b11, {6'd12, 6'd20}, {32'h1212, 32'h2020}, 2'b00, w);
        chk("lock_3", 32'(w), 32'd1);
        step(2'b11, 2'b11, {6'd13, 6'd20}, {32'h1313, 32'h2020}, 2'b00, w);
        chk("lock_rel", 32'(w), 32'd0);
`endif

        // ---------------- random traffic ----------------
        p_act = '0; p_we = '0;
        for (int k = 0; k < N; k++) begin p_addr[k] = '0; p_data[k] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!p_act[k] && $urandom_range(0, 2) != 0) begin
                    p_act[k]  = 1'b1;
                    p_we[k]   = 1'($urandom_range(0, 1));
                    p_addr[k] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7))
                                                            : 6'($urandom_range(0, 63));
                    p_data[k] = $urandom;
                end
            end
            for (int k = 0; k < N; k++) begin
                pa[k*AW +: AW] = p_addr[k];
                pd[k*DW +: DW] = p_data[k];
            end
            step(p_act, p_we, pa, pd, 2'b00, w);
            if (w >= 0) p_act[w] = 1'b0;
        end
        step(2'b00, 2'b00, '0, '0, 2'b00, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
